// File: rtl/serial_addsub_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : serial_addsub_ctrl_pkg
// Brief  : Op encodings, FSM state codes and carry-seed helper for the
//          bit-serial add/subtract sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package serial_addsub_ctrl_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Subtraction is a + ~b + 1, so the borrow-in is folded into the seed carry.
    function automatic logic carry_seed(input logic [1:0] op, input logic cin);
        logic seed;
        case (op)
            OP_ADD:  seed = 1'b0;
            OP_SUB:  seed = 1'b1;
            OP_ADC:  seed = cin;
            default: seed = ~cin;
        endcase
        return seed;
    endfunction

    function automatic logic invert_b(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_addsub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : serial_addsub_ctrl_if
// Brief  : Request/response bundle of the bit-serial add/subtract sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op, a, b, cin,
        input  ready, busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, op, a, b, cin,
        output ready, busy, done, result, cout, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/serial_addsub_ctrl_fa.sv
`default_nettype none
// ============================================================================
// Module : serial_addsub_ctrl_fa
// Brief  : 1-bit full-adder cell; the only arithmetic element of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module serial_addsub_ctrl_fa (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      s,
    output logic      cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module : serial_addsub_ctrl
// Brief  : Bit-serial WIDTH-bit add/subtract sequencer, LSB first, one bit
//          per clock through a single shared full-adder cell.
// Rev    : 1.0  initial release
// ============================================================================
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    serial_addsub_ctrl_if.slave  bus
);

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-2:0]   r_sh_q,   r_sh_d;
    logic               carry_q,  carry_d;
    logic               c_msb_q,  c_msb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;
    logic               zero_q,   zero_d;

    logic               w_fa_s;
    logic               w_fa_c;
    logic [WIDTH-1:0]   w_r_next;

    serial_addsub_ctrl_fa u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (w_fa_s),
        .cout (w_fa_c)
    );

    // Partial result with this cycle's sum bit shifted in; on the last bit it is the full result.
    assign w_r_next = {w_fa_s, r_sh_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        carry_d  = carry_q;
        c_msb_d  = c_msb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = invert_b(bus.op) ? ~bus.b : bus.b;
                    carry_d = carry_seed(bus.op, bus.cin);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = w_r_next[WIDTH-1:1];
                carry_d = w_fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-2)) begin
                    c_msb_d = w_fa_c;
                end
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    result_d = w_r_next;
                    cout_d   = w_fa_c;
                    ovf_d    = w_fa_c ^ c_msb_q;
                    zero_d   = (w_r_next == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            carry_q  <= 1'b0;
            c_msb_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            carry_q  <= carry_d;
            c_msb_q  <= c_msb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.ready  = (state_q == ST_IDLE);
    assign bus.busy   = (state_q == ST_RUN);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_addsub_ctrl
// Brief  : Self-checking bench for serial_addsub_ctrl (WIDTH=16): directed
//          vector table, multi-cycle corner sequences, randomized ops.
// Rev    : 1.0  initial release
// ============================================================================
module tb_serial_addsub_ctrl;

    localparam int WIDTH   = 16;
    localparam int N_RAND  = 3000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on the operands' unsigned and signed values.
    task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output logic [15:0] r, output logic c,
                         output logic v, output logic z);
        int ua, ub, sa, sb, k, u, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        k  = (op[1] && cin) ? 1 : 0;
        if (op[0] == 1'b0) begin
            u = ua + ub + k;
            s = sa + sb + k;
            c = (u > 65535);
        end else begin
            u = ua - ub - k;
            s = sa - sb - k;
            c = (u >= 0);
        end
        r = u[15:0];
        v = (s > 32767) || (s < -32768);
        z = (r == 16'h0000);
    endtask

    // Called at a negedge; returns at the negedge after the op has fully retired.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input int inj_at,
                          output logic [15:0] r, output logic c, output logic v, output logic z,
                          output int lat, output int pulses, output logic hold_ok);
        int guard;
        logic [15:0] prev;
        guard = 0;
        while (bus.ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            failures++;
            $display("FAIL ready_wait actual=timeout required=ready");
        end
        prev      = bus.result;
        r = 'x; c = 1'bx; v = 1'bx; z = 1'bx;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.op    = 2'($urandom);
        bus.cin   = 1'($urandom);
        lat     = 0;
        pulses  = 0;
        hold_ok = 1'b1;
        for (int k = 1; k <= WIDTH + 2; k++) begin
            @(posedge clk);
            #1;
            bus.start = (k == inj_at);
            if (k == inj_at) begin
                bus.a  = 16'($urandom);
                bus.b  = 16'($urandom);
                bus.op = 2'($urandom);
            end
            @(negedge clk);
            if (bus.done === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    r = bus.result; c = bus.cout; v = bus.ovf; z = bus.zero;
                end
            end else if (lat == 0 && bus.result !== prev) begin
                hold_ok = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        logic [15:0] r, er;
        logic        c, v, z, ec, ev, ez, hold_ok;
        int          lat, pulses, ndone, idx;
        int          done_edge [3];
        logic [1:0]  sop [3];
        logic [15:0] sa [3];
        logic [15:0] sb [3];
        logic        scin [3];
        logic [1:0]  rop;
        logic [15:0] ra, rb;
        logic        rcin;

        vecs[0] = '{2'b00, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{2'b01, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{2'b01, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{2'b11, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; bus.start = 1'b0; bus.op = 2'b00;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",  32'(bus.ready),  32'd1);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_done",   32'(bus.done),   32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_flags",  32'({bus.cout, bus.ovf, bus.zero}), 32'd0);

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 0, r, c, v, z, lat, pulses, hold_ok);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].r));
            chk($sformatf("vec%0d_cout", i),   32'(c), 32'(vecs[i].c));
            chk($sformatf("vec%0d_ovf", i),    32'(v), 32'(vecs[i].v));
            chk($sformatf("vec%0d_zero", i),   32'(z), 32'(vecs[i].z));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd16);
            chk($sformatf("vec%0d_pulses", i), 32'(pulses), 32'd1);
            chk($sformatf("vec%0d_hold", i),   32'(hold_ok), 32'd1);
        end

        // start pulsed mid-run with other operands must be ignored
        run_op(2'b00, 16'h1234, 16'h0001, 1'b0, 5, r, c, v, z, lat, pulses, hold_ok);
        chk("ignore_result",  32'(r), 32'h1235);
        chk("ignore_latency", 32'(lat), 32'd16);
        chk("ignore_pulses",  32'(pulses), 32'd1);

        // Reset asserted mid-run aborts the op
        bus.op = 2'b00; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ready",  32'(bus.ready),  32'd1);
        chk("midrst_busy",   32'(bus.busy),   32'd0);
        chk("midrst_done",   32'(bus.done),   32'd0);
        chk("midrst_result", 32'(bus.result), 32'd0);
        chk("midrst_flags",  32'({bus.cout, bus.ovf, bus.zero}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        chk("midrst_no_done", 32'(pulses), 32'd0);
        run_op(2'b00, 16'h0002, 16'h0003, 1'b0, 0, r, c, v, z, lat, pulses, hold_ok);
        chk("post_rst_result",  32'(r), 32'h0005);
        chk("post_rst_latency", 32'(lat), 32'd16);

        // start held high with three operand sets
        sop[0] = 2'b00; sa[0] = 16'h1234; sb[0] = 16'h0001; scin[0] = 1'b0;
        sop[1] = 2'b01; sa[1] = 16'h8000; sb[1] = 16'h0001; scin[1] = 1'b0;
        sop[2] = 2'b10; sa[2] = 16'h00FF; sb[2] = 16'h0001; scin[2] = 1'b1;
        idx = 0; ndone = 0;
        bus.op = sop[0]; bus.a = sa[0]; bus.b = sb[0]; bus.cin = scin[0]; bus.start = 1'b1;
        for (int n = 0; n <= 53; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (ndone < 3) begin
                    done_edge[ndone] = n;
                    model(sop[ndone], sa[ndone], sb[ndone], scin[ndone], er, ec, ev, ez);
                    chk($sformatf("b2b%0d_fields", ndone),
                        32'({bus.result, bus.cout, bus.ovf, bus.zero}), 32'({er, ec, ev, ez}));
                end
                ndone++;
                idx++;
                if (idx < 3) begin
                    bus.op = sop[idx]; bus.a = sa[idx]; bus.b = sb[idx]; bus.cin = scin[idx];
                end
            end
        end
        bus.start = 1'b0;
        chk("b2b_pulses", 32'(ndone), 32'd3);
        if (ndone >= 3) begin
            chk("b2b_first_edge", 32'(done_edge[0]), 32'd16);
            chk("b2b_gap0", 32'(done_edge[1] - done_edge[0]), 32'd18);
            chk("b2b_gap1", 32'(done_edge[2] - done_edge[1]), 32'd18);
        end
        for (int k = 0; k < 25 && bus.ready !== 1'b1; k++) @(negedge clk);

        // Randomized ops against the reference model
        for (int i = 0; i < N_RAND; i++) begin
            rop  = 2'($urandom);
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rcin = 1'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'h0000;
                1: rb = ra;
                2: ra = 16'h7FFF;
                3: ra = 16'h8000;
                default: ;
            endcase
            model(rop, ra, rb, rcin, er, ec, ev, ez);
            run_op(rop, ra, rb, rcin, 0, r, c, v, z, lat, pulses, hold_ok);
            chk($sformatf("rand%0d op=%0d a=%h b=%h cin=%0d", i, rop, ra, rb, rcin),
                {r, c, v, z, 8'(lat), 4'(pulses), hold_ok},
                {er, ec, ev, ez, 8'd16, 4'd1, 1'b1});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
